// File: rtl/comfort_ctrl_param.sv
// Occupancy-aware climate/lighting controller for one zone with hysteresis, vacancy timeout and minimum run time.
// Optional setback control while vacant is enabled by defining COMFORT_ECO_EN.
module comfort_ctrl_param #(
  parameter int SENSE_W     = 8,
  parameter int T_LOW       = 15,
  parameter int T_HIGH      = 30,
  parameter int T_HYST      = 2,
  parameter int LUX_LOW     = 15,
  parameter int LUX_HYST    = 2,
  parameter int VACANCY_CYC = 1000,
  parameter int MIN_RUN_CYC = 100,
  parameter int ECO_DELTA   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid_i,
  input  logic               motion_i,
  input  logic [SENSE_W-1:0] temp_i,
  input  logic [SENSE_W-1:0] lux_i,
  output logic               heater_o,
  output logic               cooler_o,
  output logic               light_high_o,
  output logic               occupied_o,
  output logic [1:0]         state_o
);

  localparam int VW = $clog2(VACANCY_CYC + 1);
  localparam int RW = $clog2(MIN_RUN_CYC + 1);

  if ((T_LOW + T_HYST >= T_HIGH - T_HYST) || (ECO_DELTA < 0) ||
      (VACANCY_CYC < 1) || (MIN_RUN_CYC < 1)) begin : g_bad_params
    $error("comfort_ctrl_param: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    VACANT = 2'd0,
    IDLE   = 2'd1,
    HEAT   = 2'd2,
    COOL   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SENSE_W-1:0] temp_q, temp_d, lux_q, lux_d;
  logic [VW-1:0]     vac_cnt_q, vac_cnt_d;
  logic [RW-1:0]     run_cnt_q, run_cnt_d;
  logic              occ_q, occ_d, light_q, light_d;
  logic              heat_done, cool_done;
  int                t_val, l_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= VACANT;
      temp_q    <= SENSE_W'((T_LOW + T_HIGH) / 2);
      lux_q     <= '1;
      vac_cnt_q <= '0;
      run_cnt_q <= '0;
      occ_q     <= 1'b0;
      light_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      temp_q    <= temp_d;
      lux_q     <= lux_d;
      vac_cnt_q <= vac_cnt_d;
      run_cnt_q <= run_cnt_d;
      occ_q     <= occ_d;
      light_q   <= light_d;
    end
  end

  // Sensor capture and occupancy timer; motion wins over expiry.
  always_comb begin
    temp_d    = sample_valid_i ? temp_i : temp_q;
    lux_d     = sample_valid_i ? lux_i  : lux_q;
    occ_d     = occ_q;
    vac_cnt_d = vac_cnt_q;
    if (motion_i) begin
      occ_d     = 1'b1;
      vac_cnt_d = VW'(VACANCY_CYC - 1);
    end else if (vac_cnt_q == '0) begin
      occ_d = 1'b0;
    end else begin
      vac_cnt_d = vac_cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_cnt_d = (run_cnt_q != '0) ? run_cnt_q - 1'b1 : '0;
    t_val     = int'(temp_q);
`ifdef COMFORT_ECO_EN
    heat_done = occ_q ? (t_val >= T_LOW + T_HYST)  : (t_val >= T_LOW - ECO_DELTA + T_HYST);
    cool_done = occ_q ? (t_val <= T_HIGH - T_HYST) : (t_val <= T_HIGH + ECO_DELTA - T_HYST);
`else
    heat_done = !occ_q || (t_val >= T_LOW + T_HYST);
    cool_done = !occ_q || (t_val <= T_HIGH - T_HYST);
`endif
    case (state_q)
      VACANT: begin
        if (occ_q) state_d = IDLE;
`ifdef COMFORT_ECO_EN
        else if (t_val < T_LOW - ECO_DELTA)  state_d = HEAT;
        else if (t_val > T_HIGH + ECO_DELTA) state_d = COOL;
`endif
      end
      IDLE: begin
        if (!occ_q)              state_d = VACANT;
        else if (t_val < T_LOW)  state_d = HEAT;
        else if (t_val > T_HIGH) state_d = COOL;
      end
      HEAT: if (run_cnt_q == '0 && heat_done) state_d = occ_q ? IDLE : VACANT;
      COOL: if (run_cnt_q == '0 && cool_done) state_d = occ_q ? IDLE : VACANT;
      default: state_d = VACANT;
    endcase
    // Minimum run time starts on the edge that enters an active state.
    if ((state_d == HEAT || state_d == COOL) && state_d != state_q)
      run_cnt_d = RW'(MIN_RUN_CYC - 1);
  end

  always_comb begin
    light_d = light_q;
    l_val   = int'(lux_q);
    if (!occ_q)                            light_d = 1'b0;
    else if (l_val < LUX_LOW)              light_d = 1'b1;
    else if (l_val >= LUX_LOW + LUX_HYST)  light_d = 1'b0;
  end

  assign heater_o     = (state_q == HEAT);
  assign cooler_o     = (state_q == COOL);
  assign light_high_o = light_q;
  assign occupied_o   = occ_q;
  assign state_o      = state_q;

endmodule
